// File: rtl/kronos_id_scoreboard.sv
// Decode-stage issue register with per-register pending-write counters,
// RAW/WAW/saturation stall and same-cycle writeback forwarding.
module kronos_id_scoreboard #(
    parameter int unsigned NUM_WB    = 2,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned FORWARD   = 1,
    parameter int unsigned WAW_STALL = 0
) (
    input  logic                    clk,
    input  logic                    rstz,
    input  logic                    flush,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [4:0]              in_rs1,
    input  logic [4:0]              in_rs2,
    input  logic                    in_rs1_en,
    input  logic                    in_rs2_en,
    input  logic [31:0]             in_rs1_data,
    input  logic [31:0]             in_rs2_data,
    input  logic [4:0]              in_rd,
    input  logic                    in_rd_en,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [4:0]              out_rd,
    output logic                    out_rd_en,
    output logic [31:0]             out_rs1_data,
    output logic [31:0]             out_rs2_data,
    input  logic [NUM_WB-1:0]       wb_en,
    input  logic [NUM_WB*5-1:0]     wb_sel,
    input  logic [NUM_WB*32-1:0]    wb_data,
    output logic [31:0]             pending
);

    localparam int unsigned REG_W   = 5;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned NREG    = 32;
    localparam int unsigned HIT_W   = 3;
    localparam int unsigned CMP_W   = CNT_W + HIT_W;
    localparam int unsigned DELTA_W = CNT_W + 4;

    logic [NREG-1:0][CNT_W-1:0] r_cnt;
    logic [NREG-1:0][CNT_W-1:0] w_cnt_nxt;
    logic                       r_out_vld;
    logic [REG_W-1:0]           r_out_rd;
    logic                       r_out_rd_en;
    logic [XLEN-1:0]            r_out_rs1;
    logic [XLEN-1:0]            r_out_rs2;

    logic [REG_W-1:0]           w_wb_sel  [NUM_WB];
    logic [XLEN-1:0]            w_wb_data [NUM_WB];
    logic [HIT_W-1:0]           w_rs1_hits;
    logic [HIT_W-1:0]           w_rs2_hits;
    logic                       w_rs1_wb;
    logic                       w_rs2_wb;
    logic [XLEN-1:0]            w_rs1_op;
    logic [XLEN-1:0]            w_rs2_op;
    logic                       w_hit_rs1;
    logic                       w_hit_rs2;
    logic                       w_fwd_rs1;
    logic                       w_fwd_rs2;
    logic                       w_raw;
    logic                       w_waw;
    logic                       w_sat;
    logic                       w_stall;
    logic                       w_acc;
    logic                       w_inc_en;
    logic                       w_fdec;
    logic                       w_uflow;
    logic [DELTA_W-1:0]         w_sum;

    always_comb begin
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            w_wb_sel[i]  = wb_sel[i*REG_W +: REG_W];
            w_wb_data[i] = wb_data[i*XLEN +: XLEN];
        end
    end

    // Per-source hit count plus lowest-index writeback bypass (register-file write-through)
    always_comb begin
        w_rs1_hits = '0;
        w_rs2_hits = '0;
        w_rs1_wb   = 1'b0;
        w_rs2_wb   = 1'b0;
        w_rs1_op   = in_rs1_data;
        w_rs2_op   = in_rs2_data;
        for (int i = int'(NUM_WB) - 1; i >= 0; i--) begin
            if (wb_en[i] && (w_wb_sel[i] == in_rs1) && (in_rs1 != '0)) begin
                w_rs1_hits = w_rs1_hits + HIT_W'(1);
                w_rs1_wb   = 1'b1;
                w_rs1_op   = w_wb_data[i];
            end
            if (wb_en[i] && (w_wb_sel[i] == in_rs2) && (in_rs2 != '0)) begin
                w_rs2_hits = w_rs2_hits + HIT_W'(1);
                w_rs2_wb   = 1'b1;
                w_rs2_op   = w_wb_data[i];
            end
        end
    end

    always_comb begin
        w_hit_rs1 = in_rs1_en && (in_rs1 != '0) && (r_cnt[in_rs1] != '0);
        w_hit_rs2 = in_rs2_en && (in_rs2 != '0) && (r_cnt[in_rs2] != '0);
        // Forwarding only clears a hazard when this cycle retires every in-flight write
        w_fwd_rs1 = (FORWARD != 0) && w_rs1_wb &&
                    (CMP_W'(r_cnt[in_rs1]) == CMP_W'(w_rs1_hits));
        w_fwd_rs2 = (FORWARD != 0) && w_rs2_wb &&
                    (CMP_W'(r_cnt[in_rs2]) == CMP_W'(w_rs2_hits));
        w_raw     = (w_hit_rs1 && !w_fwd_rs1) || (w_hit_rs2 && !w_fwd_rs2);
        w_waw     = (WAW_STALL != 0) && in_rd_en && (in_rd != '0) && (r_cnt[in_rd] != '0);
        w_sat     = in_rd_en && (in_rd != '0) && (r_cnt[in_rd] == {CNT_W{1'b1}});
        w_stall   = w_raw || w_waw || w_sat;
    end

    assign in_rdy   = (!r_out_vld || out_rdy) && !w_stall && !flush;
    assign w_acc    = in_vld && in_rdy;
    assign w_inc_en = w_acc && in_rd_en && (in_rd != '0);
    assign w_fdec   = flush && r_out_vld && r_out_rd_en && (r_out_rd != '0) && !out_rdy;

    // Net counter update; the MSB of w_sum flags a would-be negative count
    always_comb begin
        w_cnt_nxt    = '0;
        w_uflow      = 1'b0;
        w_sum        = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            w_sum = DELTA_W'(r_cnt[r]);
            if (w_inc_en && (in_rd == REG_W'(r))) begin
                w_sum = w_sum + DELTA_W'(1);
            end
            for (int unsigned i = 0; i < NUM_WB; i++) begin
                if (wb_en[i] && (w_wb_sel[i] == REG_W'(r))) begin
                    w_sum = w_sum - DELTA_W'(1);
                end
            end
            if (w_fdec && (r_out_rd == REG_W'(r))) begin
                w_sum = w_sum - DELTA_W'(1);
            end
            if (w_sum[DELTA_W-1]) begin
                w_cnt_nxt[r] = '0;
                w_uflow      = 1'b1;
            end else begin
                w_cnt_nxt[r] = CNT_W'(w_sum);
            end
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Issue register: flush beats accept beats drain
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_out_vld   <= 1'b0;
            r_out_rd    <= '0;
            r_out_rd_en <= 1'b0;
            r_out_rs1   <= '0;
            r_out_rs2   <= '0;
        end else if (flush) begin
            r_out_vld   <= 1'b0;
        end else if (w_acc) begin
            r_out_vld   <= 1'b1;
            r_out_rd    <= in_rd;
            r_out_rd_en <= in_rd_en;
            r_out_rs1   <= w_rs1_op;
            r_out_rs2   <= w_rs2_op;
        end else if (out_rdy) begin
            r_out_vld   <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            pending[r] = (r_cnt[r] != '0);
        end
    end

    assign out_vld      = r_out_vld;
    assign out_rd       = r_out_rd;
    assign out_rd_en    = r_out_rd_en;
    assign out_rs1_data = r_out_rs1;
    assign out_rs2_data = r_out_rs2;

    a_no_underflow: assert property (@(posedge clk) disable iff (!rstz) !w_uflow);

endmodule

// File: tb/tb_kronos_id_scoreboard.sv
// Directed per-cycle vector table plus hand sequences for kronos_id_scoreboard
// (default parameters: NUM_WB=2, CNT_W=2, FORWARD=1, WAW_STALL=0).
module tb_kronos_id_scoreboard;

    logic        clk = 1'b0;
    logic        rstz;
    logic        flush;
    logic        in_vld;
    logic        in_rdy;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rs1_en, in_rs2_en, in_rd_en;
    logic [31:0] in_rs1_data, in_rs2_data;
    logic        out_vld, out_rdy, out_rd_en;
    logic [4:0]  out_rd;
    logic [31:0] out_rs1_data, out_rs2_data;
    logic [1:0]  wb_en;
    logic [9:0]  wb_sel;
    logic [63:0] wb_data;
    logic [31:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    kronos_id_scoreboard dut (
        .clk(clk), .rstz(rstz), .flush(flush),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_rd(in_rd), .in_rd_en(in_rd_en),
        .out_vld(out_vld), .out_rdy(out_rdy),
        .out_rd(out_rd), .out_rd_en(out_rd_en),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl, vld;
        logic [4:0]  rs1; logic e1;
        logic [4:0]  rs2; logic e2;
        logic [4:0]  rd;  logic rde;
        logic        ordy;
        logic [1:0]  wbe;
        logic [4:0]  s0; logic [31:0] d0;
        logic [4:0]  s1; logic [31:0] d1;
        logic        xrdy, xvld, chk;
        logic [4:0]  xrd; logic xrde;
        logic [31:0] xrs1, xrs2, xpend;
    } vec_t;

    function automatic vec_t v(
        input logic fl, vld, input logic [4:0] rs1, input logic e1,
        input logic [4:0] rs2, input logic e2, input logic [4:0] rd, input logic rde,
        input logic ordy, input logic [1:0] wbe, input logic [4:0] s0, input logic [31:0] d0,
        input logic [4:0] s1, input logic [31:0] d1, input logic xrdy, xvld, chk,
        input logic [4:0] xrd, input logic xrde, input logic [31:0] xrs1, xrs2, xpend);
        vec_t t;
        t.fl = fl; t.vld = vld; t.rs1 = rs1; t.e1 = e1; t.rs2 = rs2; t.e2 = e2;
        t.rd = rd; t.rde = rde; t.ordy = ordy; t.wbe = wbe;
        t.s0 = s0; t.d0 = d0; t.s1 = s1; t.d1 = d1;
        t.xrdy = xrdy; t.xvld = xvld; t.chk = chk; t.xrd = xrd; t.xrde = xrde;
        t.xrs1 = xrs1; t.xrs2 = xrs2; t.xpend = xpend;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-file read data is a recognisable function of the source index
    task automatic drive(input logic fl, vld, input logic [4:0] rs1, input logic e1,
                         input logic [4:0] rs2, input logic e2, input logic [4:0] rd,
                         input logic rde, input logic ordy, input logic [1:0] wbe,
                         input logic [4:0] s0, input logic [31:0] d0,
                         input logic [4:0] s1, input logic [31:0] d1);
        flush = fl; in_vld = vld;
        in_rs1 = rs1; in_rs1_en = e1; in_rs1_data = 32'h1000_0000 | 32'(rs1);
        in_rs2 = rs2; in_rs2_en = e2; in_rs2_data = 32'h2000_0000 | 32'(rs2);
        in_rd = rd; in_rd_en = rde; out_rdy = ordy;
        wb_en = wbe; wb_sel = {s1, s0}; wb_data = {d1, d0};
    endtask

    task automatic idle(input logic ordy, input logic [1:0] wbe, input logic [4:0] s0, input logic [4:0] s1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, ordy, wbe, s0, 32'h0, s1, 32'h0);
    endtask

    vec_t tbl[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstz = 1'b0;
        idle(0, 2'b00, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset out_vld", 32'(out_vld), 32'h0);
        check("reset pending", pending, 32'h0);
        check("reset out_rd", 32'(out_rd), 32'h0);
        check("reset out_rd_en", 32'(out_rd_en), 32'h0);
        check("reset out_rs1", out_rs1_data, 32'h0);
        check("reset out_rs2", out_rs2_data, 32'h0);
        @(negedge clk);
        rstz = 1'b1;

        // fl vld rs1 e1 rs2 e2 rd rde ordy wbe s0 d0 s1 d1 | rdy vld chk rd rde rs1 rs2 pend
        tbl.push_back(v(0,1, 5,1, 0,0, 6,1, 1, 2'b00, 0,0, 0,0,  1,1,1, 6,1, 32'h10000005, 32'h20000000, 32'h40));
        tbl.push_back(v(0,1, 6,1, 0,0, 8,1, 1, 2'b00, 0,0, 0,0,  0,0,0, 0,0, 0, 0, 32'h40));
        tbl.push_back(v(0,1, 6,1, 0,0, 8,1, 1, 2'b01, 6,32'hDEADBEEF, 0,0, 1,1,1, 8,1, 32'hDEADBEEF, 32'h20000000, 32'h100));
        tbl.push_back(v(0,1, 0,0, 0,0, 3,1, 1, 2'b00, 0,0, 0,0,  1,1,1, 3,1, 32'h10000000, 32'h20000000, 32'h108));
        tbl.push_back(v(0,1, 0,0, 0,0, 3,1, 1, 2'b00, 0,0, 0,0,  1,1,1, 3,1, 32'h10000000, 32'h20000000, 32'h108));
        tbl.push_back(v(0,1, 3,1, 3,1, 10,1, 1, 2'b11, 3,32'hAAAA0000, 3,32'hBBBB0000, 1,1,1, 10,1, 32'hAAAA0000, 32'hAAAA0000, 32'h500));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1, 2'b11, 8,0, 10,0, 1,0,0, 0,0, 0, 0, 32'h0));
        tbl.push_back(v(0,1, 0,0, 0,0, 7,1, 1, 2'b00, 0,0, 0,0,  1,1,1, 7,1, 32'h10000000, 32'h20000000, 32'h80));
        tbl.push_back(v(0,1, 0,0, 0,0, 7,1, 1, 2'b00, 0,0, 0,0,  1,1,1, 7,1, 32'h10000000, 32'h20000000, 32'h80));
        tbl.push_back(v(0,1, 0,0, 0,0, 7,1, 1, 2'b00, 0,0, 0,0,  1,1,1, 7,1, 32'h10000000, 32'h20000000, 32'h80));
        tbl.push_back(v(0,1, 0,0, 0,0, 7,1, 1, 2'b00, 0,0, 0,0,  0,0,0, 0,0, 0, 0, 32'h80));
        tbl.push_back(v(0,1, 0,0, 0,0, 7,1, 1, 2'b01, 7,0, 0,0,  0,0,0, 0,0, 0, 0, 32'h80));
        tbl.push_back(v(0,1, 0,0, 0,0, 7,1, 1, 2'b00, 0,0, 0,0,  1,1,1, 7,1, 32'h10000000, 32'h20000000, 32'h80));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1, 2'b11, 7,0, 7,0,  1,0,0, 0,0, 0, 0, 32'h80));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1, 2'b01, 7,0, 0,0,  1,0,0, 0,0, 0, 0, 32'h0));
        tbl.push_back(v(0,1, 0,0, 0,0, 9,1, 0, 2'b00, 0,0, 0,0,  1,1,1, 9,1, 32'h10000000, 32'h20000000, 32'h200));
        tbl.push_back(v(1,1, 0,0, 0,0, 12,1, 0, 2'b00, 0,0, 0,0, 0,0,0, 0,0, 0, 0, 32'h0));
        tbl.push_back(v(0,1, 0,0, 0,0, 9,1, 0, 2'b00, 0,0, 0,0,  1,1,1, 9,1, 32'h10000000, 32'h20000000, 32'h200));
        tbl.push_back(v(1,0, 0,0, 0,0, 0,0, 1, 2'b00, 0,0, 0,0,  0,0,0, 0,0, 0, 0, 32'h200));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0, 1, 2'b01, 9,0, 0,0,  1,0,0, 0,0, 0, 0, 32'h0));
        tbl.push_back(v(0,1, 0,1, 0,1, 0,1, 1, 2'b11, 0,32'h0BAD0000, 0,32'h0BAD0001, 1,1,1, 0,1, 32'h10000000, 32'h20000000, 32'h0));
        tbl.push_back(v(0,1, 0,1, 0,0, 0,1, 1, 2'b00, 0,0, 0,0,  1,1,1, 0,1, 32'h10000000, 32'h20000000, 32'h0));
        tbl.push_back(v(0,1, 0,0, 0,0, 11,1, 1, 2'b00, 0,0, 0,0, 1,1,1, 11,1, 32'h10000000, 32'h20000000, 32'h800));
        tbl.push_back(v(0,1, 0,0, 0,0, 11,1, 1, 2'b00, 0,0, 0,0, 1,1,1, 11,1, 32'h10000000, 32'h20000000, 32'h800));
        tbl.push_back(v(0,1, 11,1, 0,0, 0,0, 1, 2'b01, 11,32'h11111111, 0,0, 0,0,0, 0,0, 0, 0, 32'h800));
        tbl.push_back(v(0,1, 11,1, 0,0, 0,0, 1, 2'b10, 0,0, 11,32'h22222222, 1,1,1, 0,0, 32'h22222222, 32'h20000000, 32'h0));

        foreach (tbl[k]) begin
            vec_t t;
            t = tbl[k];
            @(negedge clk);
            drive(t.fl, t.vld, t.rs1, t.e1, t.rs2, t.e2, t.rd, t.rde, t.ordy, t.wbe, t.s0, t.d0, t.s1, t.d1);
            #1;
            check($sformatf("v%0d in_rdy", k), 32'(in_rdy), 32'(t.xrdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_vld", k), 32'(out_vld), 32'(t.xvld));
            check($sformatf("v%0d pending", k), pending, t.xpend);
            if (t.chk) begin
                check($sformatf("v%0d out_rd", k), 32'(out_rd), 32'(t.xrd));
                check($sformatf("v%0d out_rd_en", k), 32'(out_rd_en), 32'(t.xrde));
                check($sformatf("v%0d out_rs1", k), out_rs1_data, t.xrs1);
                check($sformatf("v%0d out_rs2", k), out_rs2_data, t.xrs2);
            end
        end

        // Back-to-back issue with the consumer always ready
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(0, 1, 0, 0, 0, 0, 5'(i), 1, 1, 2'b00, 0, 0, 0, 0);
            #1;
            check($sformatf("stream%0d in_rdy", i), 32'(in_rdy), 32'h1);
            @(posedge clk);
            #1;
            check($sformatf("stream%0d out_vld", i), 32'(out_vld), 32'h1);
            check($sformatf("stream%0d out_rd", i), 32'(out_rd), 32'(i));
        end
        check("stream pending", pending, 32'h1E);
        @(negedge clk); idle(1, 2'b11, 1, 2);
        @(negedge clk); idle(1, 2'b11, 3, 4);
        @(posedge clk); #1;
        check("stream drained", pending, 32'h0);
        check("stream out_vld idle", 32'(out_vld), 32'h0);

        // Reset in the middle of traffic discards all in-flight writes
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 13, 1, 1, 2'b00, 0, 0, 0, 0);
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 14, 1, 1, 2'b00, 0, 0, 0, 0);
        @(posedge clk); #1;
        check("pre-reset pending", pending, 32'h6000);
        @(negedge clk);
        idle(1, 2'b00, 0, 0);
        rstz = 1'b0;
        #1;
        check("midreset pending", pending, 32'h0);
        check("midreset out_vld", 32'(out_vld), 32'h0);
        check("midreset out_rd", 32'(out_rd), 32'h0);
        @(negedge clk);
        rstz = 1'b1;
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 15, 1, 1, 2'b00, 0, 0, 0, 0);
        #1;
        check("postreset in_rdy", 32'(in_rdy), 32'h1);
        @(posedge clk); #1;
        check("postreset pending", pending, 32'h8000);
        check("postreset out_rd", 32'(out_rd), 32'd15);
        @(negedge clk); idle(1, 2'b01, 15, 0);
        @(posedge clk); #1;
        check("final pending", pending, 32'h0);
        @(negedge clk); idle(1, 2'b00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/kronos_id_scoreboard.md
Name: kronos_id_scoreboard

Overview:
Parametrised successor to the decode-stage hazard logic. It tracks pending register writes per architectural register with saturating counters and accepts writebacks from NUM_WB ports. It holds one decoded instruction in an output register with a valid/ready handshake, stalls on RAW hazards and, optionally, on WAW hazards, and forwards same-cycle writeback data to the operand outputs. It sits between register-file read and the EX stage.

Parameters:
NUM_WB, 2, number of writeback ports, 1..4; port 0 has highest priority for forwarding.
CNT_W, 2, pending-counter width; at most 2^CNT_W-1 in-flight writes per register.
FORWARD, 1, 1 = same-cycle writeback forwarding clears a RAW stall; 0 = stall until retire.
WAW_STALL, 0, 1 = also stall when rd already has a pending write.

Ports:
clk  in  1  clock
rstz  in  1  asynchronous active-low reset
flush  in  1  kill output register; highest priority
in_vld  in  1  decoded instruction valid
in_rdy  out  1  accept; transfer when in_vld & in_rdy
in_rs1 / in_rs2  in  5 each  source selects
in_rs1_en / in_rs2_en  in  1 each  source used
in_rs1_data / in_rs2_data  in  32 each  register-file read data
in_rd  in  5  destination
in_rd_en  in  1  instruction writes rd
out_vld  out  1  issued instruction valid
out_rdy  in  1  EX accepts
out_rd  out  5  registered rd
out_rd_en  out  1  registered rd_en
out_rs1_data / out_rs2_data  out  32 each  registered operands (post-forward)
wb_en  in  NUM_WB  writeback strobes
wb_sel  in  NUM_WB*5  writeback selects, port i at [5i+4:5i]
wb_data  in  NUM_WB*32  writeback data
pending  out  32  bit r = counter[r] != 0; bit 0 always 0

Behaviour:
- Reset (async, rstz low): out_vld=0, all counters=0, pending=0; out_rd, out_rd_en and out_rs*_data reset to 0.
- Register 0 is never tracked: wb and rd with sel 0 are ignored; a source of x0 never hazards.
- Ports with wb_en=0 are ignored.
- hit_s = in_rsX_en & (in_rsX != 0) & counter[in_rsX] != 0.
- fwd_s = FORWARD & some wb port i has wb_en[i] & wb_sel[i]==in_rsX & counter[in_rsX]==(number of enabled ports hitting in_rsX this cycle).
- raw = (hit_rs1 & ~fwd_rs1) | (hit_rs2 & ~fwd_rs2).
- waw = WAW_STALL & in_rd_en & (in_rd != 0) & counter[in_rd] != 0.
- sat = in_rd_en & (in_rd != 0) & counter[in_rd] == max.
- stall = raw | waw | sat.
- in_rdy = (~out_vld | out_rdy) & ~stall & ~flush. This is combinational.
- Operand select: forwarded data comes from the lowest-index matching port. Otherwise in_rsX_data is used, with the same lowest-index forwarding from any wb port hitting the source even when the counter is 0, matching register-file write-through.
- Accept: out_* are loaded the cycle after transfer; out_vld=1. counter[in_rd] is incremented at accept when in_rd_en & in_rd != 0.
- Output: out_vld clears on out_rdy when no new accept occurs.
- Writeback: each enabled port decrements counter[wb_sel[i]] by 1. Multiple ports may hit the same register; the net delta is summed.
- Net update per register = +accept_inc - wb_hits - flush_dec. Underflow clamps at 0 and is an assertion error.
- Flush: out_vld<=0 next cycle. If out_vld & out_rd_en & out_rd != 0 and out_rdy=0, counter[out_rd] is decremented, cancelling the unissued write. If out_rdy=1 in the same cycle, the instruction issued and no decrement occurs. Any in_vld is not accepted during flush.
- Latency: 1 cycle from in transfer to out_vld. With no hazard and out_rdy held high, throughput is 1/cycle.
- A reset mid-operation clears all counters regardless of in-flight writes.

Test Plan:
- Reset then in: rs1=x5, rd=x6, no pending -> in_rdy=1, out_vld next cycle, counter[6]=1, pending[6]=1.
- RAW stall, x6 pending, no wb; in: rs1=x6 -> in_rdy=0 until wb_en[0]=1 with wb_sel=6 and wb_data=0xDEAD_BEEF. With FORWARD=1, accept occurs that cycle and out_rs1_data=0xDEADBEEF. With FORWARD=0, accept occurs the next cycle.
- Two ports write x3 together, counter[3]=2 -> counter[3]=0 next cycle. Forwarded data comes from port 0.
- Saturation, CNT_W=2: issue three writes to x7 with no wb -> fourth rd=x7 stalls. One wb releases it.
- Flush with out_vld=1, out_rd=x9, out_rdy=0 -> out_vld=0 and counter[9] returns to its prior value. Repeat with out_rdy=1 -> counter unchanged.
- x0 as rd, rs and wb_sel -> never stalls, pending[0]=0, counters unchanged.
